load_store_queue: RTL and testbench

LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

---
 rtl/load_store_queue_if.sv | 20 ++
 rtl/load_store_queue.sv | 262 ++++++++++++++++++++++++++
 tb/tb_load_store_queue.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_queue_if.sv
// Memory-side request/response bus between the load/store queue and the data memory.
interface load_store_queue_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_queue.sv
// In-order load/store queue: circular entry buffer, single-outstanding memory FSM, CDB result/ready broadcast.
// Optional misaligned-access trap enabled by defining LSQ_MISALIGN_TRAP_EN.
module load_store_queue #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             dsp_valid,
  input  logic [3:0]       dsp_type,
  input  logic [ROB_W-1:0] dsp_rob_id,
  output logic             full,
  input  logic             alu_valid,
  input  logic [ROB_W-1:0] alu_rob_id,
  input  logic [31:0]      alu_addr,
  input  logic             std_valid,
  input  logic [ROB_W-1:0] std_rob_id,
  input  logic [31:0]      std_data,
  input  logic             cmt_valid,
  input  logic [ROB_W-1:0] cmt_rob_id,
  load_store_queue_if.master mem,
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_rob_id,
  output logic [31:0]      cdb_value,
  output logic             cdb_exc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  logic [DEPTH-1:0] e_valid, e_addr_v, e_data_v, e_cmt, e_sent, e_store;
  logic [2:0]       e_f3   [DEPTH];
  logic [ROB_W-1:0] e_rob  [DEPTH];
  logic [31:0]      e_addr [DEPTH];
  logic [31:0]      e_data [DEPTH];

  ptr_t   head_q, tail_q;
  cnt_t   count_q;
  state_t state_q, state_d;
  logic   drop_q, resp_exc_q;
  logic [31:0] resp_data_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [1:0]  mem_size_q;

  logic h_ok, h_mis, issue, trap, retire, do_disp;
  logic st_any, st_fire, resp_cdb;
  ptr_t st_idx;
  logic [DEPTH-1:0] keep_mask;
  cnt_t keep_cnt;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'd0, d[7:0]};
      3'b101:  return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] store_fmt(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    return {24'd0, d[7:0]};
      2'd1:    return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

`ifdef LSQ_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return lo[0];
      default: return lo != 2'd0;
    endcase
  endfunction

  assign h_mis   = misaligned(e_f3[head_q][1:0], e_addr[head_q][1:0]);
  assign cdb_exc = cdb_valid && resp_cdb && resp_exc_q;
`else
  assign h_mis   = 1'b0;
  assign cdb_exc = 1'b0;
`endif

  assign full    = (count_q == cnt_t'(DEPTH));
  assign do_disp = dsp_valid && !full && !clear_in;
  // Stores additionally need their data and a ROB commit before touching memory.
  assign h_ok    = e_valid[head_q] && e_addr_v[head_q] &&
                   (!e_store[head_q] || (e_data_v[head_q] && e_cmt[head_q]));

  assign mem.mem_req   = (state_q == BUSY);
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_size  = mem_size_q;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    trap    = 1'b0;
    retire  = 1'b0;
    case (state_q)
      IDLE: if (h_ok && !clear_in) begin
        if (h_mis) begin
          state_d = RESP;
          trap    = 1'b1;
        end else begin
          state_d = BUSY;
          issue   = 1'b1;
        end
      end
      BUSY: if (mem.mem_ack) state_d = RESP;
      RESP: begin
        state_d = IDLE;
        retire  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Oldest store holding both address and data that has not yet announced readiness.
  always_comb begin
    st_any = 1'b0;
    st_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ptr_t idx;
      idx = head_q + ptr_t'(i);
      if (e_valid[idx] && e_store[idx] && e_addr_v[idx] && e_data_v[idx] && !e_sent[idx]) begin
        st_any = 1'b1;
        st_idx = idx;
      end
    end
  end

  // On flush, survivors are the committed-store prefix plus whatever is in flight at head.
  always_comb begin
    logic run;
    run       = 1'b1;
    keep_mask = '0;
    keep_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ptr_t idx;
      idx = head_q + ptr_t'(i);
      if (run && e_valid[idx] &&
          ((e_store[idx] && e_cmt[idx]) || (i == 0 && state_q != IDLE))) begin
        keep_mask[idx] = 1'b1;
        keep_cnt       = keep_cnt + cnt_t'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  always_comb begin
    resp_cdb   = (state_q == RESP) && !drop_q && (resp_exc_q || !e_store[head_q]);
    cdb_valid  = !clear_in && (resp_cdb || st_any);
    cdb_rob_id = '0;
    cdb_value  = '0;
    st_fire    = 1'b0;
    if (cdb_valid) begin
      if (resp_cdb) begin
        cdb_rob_id = e_rob[head_q];
        cdb_value  = resp_exc_q ? e_addr[head_q] : load_ext(e_f3[head_q], resp_data_q);
      end else begin
        cdb_rob_id = e_rob[st_idx];
        st_fire    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      e_valid    <= '0;
      e_addr_v   <= '0;
      e_data_v   <= '0;
      e_cmt      <= '0;
      e_sent     <= '0;
      drop_q     <= 1'b0;
      resp_exc_q <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (e_valid[i]) begin
          if (alu_valid && alu_rob_id == e_rob[i]) e_addr_v[i] <= 1'b1;
          if (std_valid && std_rob_id == e_rob[i]) e_data_v[i] <= 1'b1;
          if (cmt_valid && cmt_rob_id == e_rob[i]) e_cmt[i]    <= 1'b1;
        end
      end
      if (st_fire) e_sent[st_idx] <= 1'b1;
      if (do_disp) begin
        e_valid[tail_q]  <= 1'b1;
        e_addr_v[tail_q] <= alu_valid && alu_rob_id == dsp_rob_id;
        e_data_v[tail_q] <= std_valid && std_rob_id == dsp_rob_id;
        e_cmt[tail_q]    <= 1'b0;
        e_sent[tail_q]   <= 1'b0;
      end
      if (clear_in) e_valid <= e_valid & keep_mask;
      if (retire) begin
        e_valid[head_q] <= 1'b0;
        head_q          <= head_q + ptr_t'(1);
      end
      if (clear_in) begin
        tail_q  <= head_q + ptr_t'(keep_cnt);
        count_q <= keep_cnt - cnt_t'(retire);
      end else begin
        tail_q  <= tail_q + ptr_t'(do_disp);
        count_q <= count_q + cnt_t'(do_disp) - cnt_t'(retire);
      end
      if (clear_in && state_d != IDLE) drop_q <= 1'b1;
      else if (state_d == IDLE)        drop_q <= 1'b0;
      if (trap)                   resp_exc_q <= 1'b1;
      else if (state_d == IDLE)   resp_exc_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (e_valid[i]) begin
          if (alu_valid && alu_rob_id == e_rob[i]) e_addr[i] <= alu_addr;
          if (std_valid && std_rob_id == e_rob[i]) e_data[i] <= std_data;
        end
      end
      if (do_disp) begin
        e_store[tail_q] <= dsp_type[3];
        e_f3[tail_q]    <= dsp_type[2:0];
        e_rob[tail_q]   <= dsp_rob_id;
        if (alu_valid && alu_rob_id == dsp_rob_id) e_addr[tail_q] <= alu_addr;
        if (std_valid && std_rob_id == dsp_rob_id) e_data[tail_q] <= std_data;
      end
      if (state_q == BUSY && mem.mem_ack) resp_data_q <= mem.mem_rdata;
    end
  end

  // Request fields are latched at issue so they stay stable for the whole BUSY period.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
    end else if (rdy_in && issue) begin
      mem_we_q    <= e_store[head_q];
      mem_addr_q  <= e_addr[head_q];
      mem_size_q  <= e_f3[head_q][1:0];
      mem_wdata_q <= e_store[head_q] ? store_fmt(e_f3[head_q][1:0], e_data[head_q]) : 32'd0;
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue (DEPTH=4): capacity, load extension, store commit, flush, freeze, trap, wrap.
module tb_load_store_queue;
  localparam int DEPTH = 4;
  localparam int ROB_W = 5;
  localparam logic [3:0] LB = 4'b0000, LH = 4'b0001, LW = 4'b0010, LBU = 4'b0100,
                         LHU = 4'b0101, SB = 4'b1000, SW = 4'b1010;

  logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, clear_in = 1'b0;
  logic dsp_valid = 1'b0, alu_valid = 1'b0, std_valid = 1'b0, cmt_valid = 1'b0;
  logic [3:0] dsp_type = '0;
  logic [ROB_W-1:0] dsp_rob_id = '0, alu_rob_id = '0, std_rob_id = '0, cmt_rob_id = '0;
  logic [31:0] alu_addr = '0, std_data = '0;
  logic full, cdb_valid, cdb_exc;
  logic [ROB_W-1:0] cdb_rob_id;
  logic [31:0] cdb_value;
  int total = 0, bad = 0;

  always #5 clk_in = ~clk_in;

  load_store_queue_if mem_bus();

  load_store_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .dsp_valid(dsp_valid), .dsp_type(dsp_type), .dsp_rob_id(dsp_rob_id), .full(full),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_addr(alu_addr),
    .std_valid(std_valid), .std_rob_id(std_rob_id), .std_data(std_data),
    .cmt_valid(cmt_valid), .cmt_rob_id(cmt_rob_id),
    .mem(mem_bus.master),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value), .cdb_exc(cdb_exc)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic disp(input logic [3:0] ty, input logic [ROB_W-1:0] rob, input logic av, input logic [31:0] addr);
    dsp_valid = 1'b1; dsp_type = ty; dsp_rob_id = rob;
    alu_valid = av; alu_rob_id = rob; alu_addr = addr;
    step();
    dsp_valid = 1'b0; alu_valid = 1'b0;
  endtask

  task automatic alu_bc(input logic [ROB_W-1:0] rob, input logic [31:0] addr);
    alu_valid = 1'b1; alu_rob_id = rob; alu_addr = addr;
    step();
    alu_valid = 1'b0;
  endtask

  task automatic std_bc(input logic [ROB_W-1:0] rob, input logic [31:0] data);
    std_valid = 1'b1; std_rob_id = rob; std_data = data;
    step();
    std_valid = 1'b0;
  endtask

  task automatic commit(input logic [ROB_W-1:0] rob);
    cmt_valid = 1'b1; cmt_rob_id = rob;
    step();
    cmt_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] a, input logic we,
                          input logic [31:0] wd, input logic [1:0] sz);
    int n;
    n = 0;
    while (mem_bus.mem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req"},  mem_bus.mem_req, 1);
    chk({tag, "_addr"}, mem_bus.mem_addr, a);
    chk({tag, "_we"},   mem_bus.mem_we, we);
    chk({tag, "_size"}, mem_bus.mem_size, sz);
    if (we) chk({tag, "_wdata"}, mem_bus.mem_wdata, wd);
  endtask

  task automatic ack(input logic [31:0] rd);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = rd;
    step();
    mem_bus.mem_ack = 1'b0;
  endtask

  task automatic chk_cdb(input string tag, input logic [ROB_W-1:0] rob, input logic [31:0] val);
    chk({tag, "_cdbv"}, cdb_valid, 1);
    chk({tag, "_rob"},  cdb_rob_id, rob);
    chk({tag, "_val"},  cdb_value, val);
    chk({tag, "_exc"},  cdb_exc, 0);
  endtask

  initial begin
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;
    step();
    step();
    chk("rst_full", full, 0);
    chk("rst_req", mem_bus.mem_req, 0);
    chk("rst_we", mem_bus.mem_we, 0);
    chk("rst_addr", mem_bus.mem_addr, 0);
    chk("rst_wdata", mem_bus.mem_wdata, 0);
    chk("rst_size", mem_bus.mem_size, 0);
    chk("rst_cdbv", cdb_valid, 0);
    chk("rst_cdbrob", cdb_rob_id, 0);
    chk("rst_cdbval", cdb_value, 0);
    chk("rst_cdbexc", cdb_exc, 0);
    rst_in = 1'b1;
    step();

    // Capacity: five back-to-back loads, fifth is dropped.
    for (int i = 0; i < 5; i++) begin
      disp(LW, ROB_W'(i), 1'b0, 32'd0);
      chk($sformatf("cap_full%0d", i), full, (i >= 3) ? 1 : 0);
    end
    for (int i = 0; i < 5; i++) alu_bc(ROB_W'(i), 32'h40 + 32'(4 * i));
    for (int i = 0; i < 4; i++) begin
      wait_req($sformatf("cap%0d", i), 32'h40 + 32'(4 * i), 1'b0, 32'd0, 2'd2);
      ack(32'h1000 + 32'(i));
      chk_cdb($sformatf("cap%0d", i), ROB_W'(i), 32'h1000 + 32'(i));
      step();
      chk($sformatf("cap_nfull%0d", i), full, 0);
    end
    repeat (3) step();
    chk("cap_fifth_ignored", mem_bus.mem_req, 0);

    // Load sign/zero extension; LB address arrives in the dispatch cycle.
    disp(LB, 5'd3, 1'b1, 32'h100);
    wait_req("lb", 32'h100, 1'b0, 32'd0, 2'd0);
    ack(32'h0000_0080);
    chk_cdb("lb", 5'd3, 32'hFFFF_FF80);
    step();
    chk("lb_once", cdb_valid, 0);
    disp(LHU, 5'd5, 1'b1, 32'h202);
    wait_req("lhu", 32'h202, 1'b0, 32'd0, 2'd1);
    ack(32'h1234_8001);
    chk_cdb("lhu", 5'd5, 32'h0000_8001);
    step();
    disp(LH, 5'd6, 1'b1, 32'h204);
    wait_req("lh", 32'h204, 1'b0, 32'd0, 2'd1);
    ack(32'h1234_8001);
    chk_cdb("lh", 5'd6, 32'hFFFF_8001);
    step();
    disp(LBU, 5'd9, 1'b1, 32'h301);
    wait_req("lbu", 32'h301, 1'b0, 32'd0, 2'd0);
    ack(32'hFFFF_FF90);
    chk_cdb("lbu", 5'd9, 32'h0000_0090);
    step();

    // Store waits for commit; readiness broadcast exactly once.
    disp(SW, 5'd2, 1'b0, 32'd0);
    alu_valid = 1'b1; alu_rob_id = 5'd2; alu_addr = 32'h20;
    std_bc(5'd2, 32'hDEAD_BEEF);
    alu_valid = 1'b0;
    chk_cdb("sw_rdy", 5'd2, 32'd0);
    step();
    chk("sw_rdy_once", cdb_valid, 0);
    chk("sw_nocmt_req", mem_bus.mem_req, 0);
    step();
    step();
    chk("sw_nocmt_req2", mem_bus.mem_req, 0);
    commit(5'd2);
    wait_req("sw", 32'h20, 1'b1, 32'hDEAD_BEEF, 2'd2);
    ack(32'd0);
    chk("sw_resp_cdb", cdb_valid, 0);
    step();

    disp(SB, 5'd7, 1'b1, 32'h31);
    std_bc(5'd7, 32'hAABB_CCDD);
    chk_cdb("sb_rdy", 5'd7, 32'd0);
    commit(5'd7);
    wait_req("sb", 32'h31, 1'b1, 32'h0000_00DD, 2'd0);
    ack(32'd0);
    step();

    // Flush: committed store drains, younger loads vanish.
    disp(SW, 5'd8, 1'b1, 32'h80);
    std_bc(5'd8, 32'h1122_3344);
    chk_cdb("fl_rdy", 5'd8, 32'd0);
    commit(5'd8);
    disp(LW, 5'd9, 1'b1, 32'h90);
    disp(LW, 5'd10, 1'b1, 32'h94);
    wait_req("fl_sw", 32'h80, 1'b1, 32'h1122_3344, 2'd2);
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    chk("fl_hold_req", mem_bus.mem_req, 1);
    ack(32'd0);
    chk("fl_resp_cdb", cdb_valid, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fl_noreq%0d", i), mem_bus.mem_req, 0);
      chk($sformatf("fl_nocdb%0d", i), cdb_valid, 0);
      step();
    end
    chk("fl_full", full, 0);
    disp(LW, 5'd11, 1'b1, 32'hA0);
    wait_req("fl_next", 32'hA0, 1'b0, 32'd0, 2'd2);
    ack(32'h99);
    chk_cdb("fl_next", 5'd11, 32'h99);
    step();

    // Flush with a load in flight: handshake completes, result suppressed.
    disp(LW, 5'd12, 1'b1, 32'hB0);
    wait_req("fl_ld", 32'hB0, 1'b0, 32'd0, 2'd2);
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    chk("fl_ld_req", mem_bus.mem_req, 1);
    ack(32'h777);
    chk("fl_ld_cdb", cdb_valid, 0);
    step();
    chk("fl_ld_cdb2", cdb_valid, 0);
    chk("fl_ld_idle", mem_bus.mem_req, 0);

    // Freeze while BUSY.
    disp(LW, 5'd14, 1'b1, 32'hC0);
    wait_req("frz", 32'hC0, 1'b0, 32'd0, 2'd2);
    rdy_in = 1'b0;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h66;
    step();
    chk("frz_req", mem_bus.mem_req, 1);
    chk("frz_cdb", cdb_valid, 0);
    step();
    chk("frz_addr", mem_bus.mem_addr, 32'hC0);
    rdy_in = 1'b1;
    step();
    mem_bus.mem_ack = 1'b0;
    chk_cdb("frz", 5'd14, 32'h66);
    step();

    // Misaligned word load.
    disp(LW, 5'd13, 1'b1, 32'h102);
`ifdef LSQ_MISALIGN_TRAP_EN
    chk("mis_noreq0", mem_bus.mem_req, 0);
    step();
    chk("mis_noreq1", mem_bus.mem_req, 0);
    chk("mis_cdbv", cdb_valid, 1);
    chk("mis_rob", cdb_rob_id, 5'd13);
    chk("mis_val", cdb_value, 32'h102);
    chk("mis_exc", cdb_exc, 1);
    step();
    chk("mis_once", cdb_valid, 0);
`else
    wait_req("mis", 32'h102, 1'b0, 32'd0, 2'd2);
    ack(32'h55);
    chk_cdb("mis", 5'd13, 32'h55);
    step();
`endif

    // Eight loads through a DEPTH=4 queue, dispatching during each retire.
    for (int i = 0; i < 3; i++) disp(LW, ROB_W'(i), 1'b1, 32'h400 + 32'(4 * i));
    for (int i = 0; i < 8; i++) begin
      wait_req($sformatf("wrap%0d", i), 32'h400 + 32'(4 * i), 1'b0, 32'd0, 2'd2);
      ack(32'h5000 + 32'(i));
      chk_cdb($sformatf("wrap%0d", i), ROB_W'(i), 32'h5000 + 32'(i));
      if (i + 3 < 8) disp(LW, ROB_W'(i + 3), 1'b1, 32'h400 + 32'(4 * (i + 3)));
      else step();
    end
    step();
    chk("wrap_empty_req", mem_bus.mem_req, 0);
    chk("wrap_full", full, 0);

    // Reset while BUSY abandons the request; a stray ack afterwards is ignored.
    disp(LW, 5'd15, 1'b1, 32'hD0);
    wait_req("rstb", 32'hD0, 1'b0, 32'd0, 2'd2);
    rst_in = 1'b0;
    #1;
    chk("rstb_req", mem_bus.mem_req, 0);
    chk("rstb_addr", mem_bus.mem_addr, 0);
    step();
    rst_in = 1'b1;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1;
    step();
    mem_bus.mem_ack = 1'b0;
    chk("rstb_req2", mem_bus.mem_req, 0);
    chk("rstb_cdb", cdb_valid, 0);
    step();
    chk("rstb_cdb2", cdb_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
